// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared key FSM encodings, default timing and counter sizing
package key_conditioner_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      HELD         = 2'd2,
      RELEASE_PEND = 2'd3
   } key_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;

   // One width serves both the stability counter and the repeat timer.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// rtl/key_conditioner_channel.sv - one pushbutton: synchronizer, debounce FSM, auto-repeat timer
module key_channel
   import key_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press,
   output logic key_release,
   output logic key_repeat
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic REPEAT_ON = (REPEAT_DELAY != 0);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   logic       sync_meta, sync;
   key_state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next, tmr, tmr_next;
   logic       rep_started, rep_started_next;
   logic       level_next, press_next, release_next, repeat_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta   <= 1'b0;
         sync        <= 1'b0;
         state       <= RELEASED;
         cnt         <= '0;
         tmr         <= '0;
         rep_started <= 1'b0;
         level       <= 1'b0;
         press       <= 1'b0;
         key_release <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         sync_meta   <= ~key_n;
         sync        <= sync_meta;
         state       <= state_next;
         cnt         <= cnt_next;
         tmr         <= tmr_next;
         rep_started <= rep_started_next;
         level       <= level_next;
         press       <= press_next;
         key_release <= release_next;
         key_repeat  <= repeat_next;
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      tmr_next         = tmr;
      rep_started_next = rep_started;
      press_next       = 1'b0;
      release_next     = 1'b0;
      repeat_next      = 1'b0;

      case (state)
         RELEASED: begin
            if (sync) begin
               state_next = PRESS_PEND;
               cnt_next   = '0;
            end
         end
         PRESS_PEND: begin
            if (!sync) begin
               state_next = RELEASED;
            end else if (cnt == DEB_LAST) begin
               state_next = HELD;
               press_next = 1'b1;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         HELD: begin
            if (!sync) begin
               state_next = RELEASE_PEND;
               cnt_next   = '0;
            end
         end
         RELEASE_PEND: begin
            if (sync) begin
               state_next = HELD;
            end else if (cnt == DEB_LAST) begin
               state_next   = RELEASED;
               release_next = 1'b1;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         default: state_next = RELEASED;
      endcase

      // Repeat cadence runs off the accepted press and ignores release bounces.
      if (press_next) begin
         tmr_next         = '0;
         rep_started_next = 1'b0;
      end else if (state == HELD || state == RELEASE_PEND) begin
         if (REPEAT_ON && !release_next && tmr == (rep_started ? PER_LAST : DLY_LAST)) begin
            repeat_next      = 1'b1;
            tmr_next         = '0;
            rep_started_next = 1'b1;
         end else begin
            tmr_next = sat_inc(tmr);
         end
      end

      level_next = (state_next == HELD) || (state_next == RELEASE_PEND);
   end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N_KEYS independent debounced pushbutton channels with auto-repeat
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] level,
   output logic [N_KEYS-1:0] press,
   // release/repeat are reserved words, hence the key_ prefix
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_channel (
         .clk        (clk),
         .reset      (reset),
         .key_n      (key_n[k]),
         .level      (level[k]),
         .press      (press[k]),
         .key_release(key_release[k]),
         .key_repeat (key_repeat[k])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3)
module tb_key_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_n;
   logic [3:0] level, press, key_release, key_repeat;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t;

   typedef struct {
      int         at;
      logic [3:0] p;
      logic [3:0] r;
      logic [3:0] rp;
      logic [3:0] l;
   } ev_t;
   ev_t q[$];

   key_conditioner #(
      .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .level(level),
      .press(press), .key_release(key_release), .key_repeat(key_repeat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                                     input logic [3:0] rp, input logic [3:0] l);
      ev_t e;
      e.at = at; e.p = p; e.r = r; e.rp = rp; e.l = l;
      q.push_back(e);
   endfunction

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: every pulse cycle must match the next expected event exactly.
   always @(negedge clk) begin
      if (reset === 1'b0 && (press | key_release | key_repeat) != 4'b0) begin
         n_vec++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse @%0d: press=%b rel=%b rpt=%b level=%b, want none",
                     cyc, press, key_release, key_repeat, level);
         end else begin
            ev_t e;
            e = q.pop_front();
            if (e.at != cyc || e.p !== press || e.r !== key_release || e.rp !== key_repeat
                || e.l !== level) begin
               n_bad++;
               $display("FAIL event @%0d: got press=%b rel=%b rpt=%b level=%b, want @%0d press=%b rel=%b rpt=%b level=%b",
                        cyc, press, key_release, key_repeat, level, e.at, e.p, e.r, e.rp, e.l);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      key_n = 4'hF;
      repeat (3) @(negedge clk);
      check("reset_outputs", {level, press, key_release, key_repeat}, 16'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_level", {12'h0, level}, 16'h0);

      // key 0 single press then release before first repeat
      @(negedge clk); t = cyc;
      key_n[0] = 1'b0;
      expect_ev(t + 7, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      expect_ev(t + 16, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      wait_cyc(t + 9);
      key_n[0] = 1'b1;
      wait_cyc(t + 20);

      // key 1 glitch shorter than the debounce window
      t = cyc;
      key_n[1] = 1'b0;
      wait_cyc(t + 3);
      key_n[1] = 1'b1;
      wait_cyc(t + 8);
      check("glitch_level", {12'h0, level}, 16'h0);
      wait_cyc(t + 14);

      // key 2 held through repeats; release lands on a repeat slot
      t = cyc;
      key_n[2] = 1'b0;
      expect_ev(t + 7, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      for (int i = 0; i < 5; i++)
         expect_ev(t + 17 + 3 * i, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      expect_ev(t + 32, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      wait_cyc(t + 25);
      key_n[2] = 1'b1;
      wait_cyc(t + 38);

      // key 3 one-cycle bounce while held
      t = cyc;
      key_n[3] = 1'b0;
      expect_ev(t + 7, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
      for (int i = 0; i < 4; i++)
         expect_ev(t + 17 + 3 * i, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
      expect_ev(t + 28, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
      wait_cyc(t + 12);
      key_n[3] = 1'b1;
      wait_cyc(t + 13);
      key_n[3] = 1'b0;
      wait_cyc(t + 15);
      check("bounce_level", {12'h0, level}, 16'h0008);
      wait_cyc(t + 21);
      key_n[3] = 1'b1;
      wait_cyc(t + 34);

      // keys 0 and 3 together
      t = cyc;
      key_n = 4'b0110;
      expect_ev(t + 7, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
      expect_ev(t + 15, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
      wait_cyc(t + 8);
      key_n = 4'hF;
      wait_cyc(t + 20);

      // reset during key 2 hold and key 1 debounce
      t = cyc;
      key_n[2] = 1'b0;
      expect_ev(t + 7, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      wait_cyc(t + 8);
      key_n[1] = 1'b0;
      wait_cyc(t + 11);
      check("pre_reset_level", {12'h0, level}, 16'h0004);
      reset = 1'b1;
      #1;
      check("async_reset", {level, press, key_release, key_repeat}, 16'h0);
      wait_cyc(t + 13);
      reset = 1'b0;
      expect_ev(t + 20, 4'b0110, 4'b0000, 4'b0000, 4'b0110);
      expect_ev(t + 28, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
      wait_cyc(t + 19);
      check("post_reset_pending", {12'h0, level}, 16'h0);
      wait_cyc(t + 21);
      key_n = 4'hF;
      wait_cyc(t + 40);

      check("events_outstanding", 16'(q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
